// File: rtl/pipe_ser_pkg.sv
// Shared types and helpers for the FFT output lane serializer.
package pipe_ser_pkg;

  localparam int LANES  = 16;
  localparam int LANE_W = 4;
  localparam logic [LANE_W-1:0] SLOT_LAST = LANE_W'(LANES - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    DRAIN = 1'b1
  } state_e;

  function automatic logic [LANE_W-1:0] bitrev4(input logic [LANE_W-1:0] v);
    logic [LANE_W-1:0] r;
    for (int i = 0; i < LANE_W; i++) r[i] = v[LANE_W-1-i];
    return r;
  endfunction

endpackage

// File: rtl/pipe_ser_lane_mux.sv
// 16:1 lane select from the holding bank onto the serial data bus.
module pipe_ser_lane_mux
  import pipe_ser_pkg::*;
#(
  parameter int D_WIDTH = 192
) (
  input  logic [LANES-1:0][D_WIDTH-1:0] bank_i,
  input  logic [LANE_W-1:0]             sel_i,
  output logic [D_WIDTH-1:0]            data_o
);

  assign data_o = bank_i[sel_i];

endmodule

// File: rtl/pipe_serializer.sv
// Parallel-to-serial drain of one 16-lane FFT butterfly vector, one lane per cycle.
// Define PIPE_SER_BITREV_EN to emit lanes in 4-bit bit-reversed order.
module pipe_serializer
  import pipe_ser_pkg::*;
#(
  parameter int D_WIDTH       = 192,
  parameter int VEC_PER_FRAME = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [D_WIDTH-1:0] R0_in,
  input  logic [D_WIDTH-1:0] R1_in,
  input  logic [D_WIDTH-1:0] R2_in,
  input  logic [D_WIDTH-1:0] R3_in,
  input  logic [D_WIDTH-1:0] R4_in,
  input  logic [D_WIDTH-1:0] R5_in,
  input  logic [D_WIDTH-1:0] R6_in,
  input  logic [D_WIDTH-1:0] R7_in,
  input  logic [D_WIDTH-1:0] R8_in,
  input  logic [D_WIDTH-1:0] R9_in,
  input  logic [D_WIDTH-1:0] R10_in,
  input  logic [D_WIDTH-1:0] R11_in,
  input  logic [D_WIDTH-1:0] R12_in,
  input  logic [D_WIDTH-1:0] R13_in,
  input  logic [D_WIDTH-1:0] R14_in,
  input  logic [D_WIDTH-1:0] R15_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] out_data,
  output logic [LANE_W-1:0]  out_lane,
  output logic               out_last,
  output logic               out_frame_last
);

  localparam int VW = (VEC_PER_FRAME > 1) ? $clog2(VEC_PER_FRAME) : 1;
  localparam logic [VW-1:0] VEC_LAST = VW'(VEC_PER_FRAME - 1);

  state_e                       state_q, state_d;
  logic [LANE_W-1:0]            slot_q, slot_d;
  logic [VW-1:0]                vec_q, vec_d;
  logic [LANES-1:0][D_WIDTH-1:0] bank_q, lanes_in;
  logic                         load;

  assign lanes_in = {R15_in, R14_in, R13_in, R12_in, R11_in, R10_in, R9_in, R8_in,
                     R7_in,  R6_in,  R5_in,  R4_in,  R3_in,  R2_in,  R1_in, R0_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      slot_q  <= '0;
      vec_q   <= '0;
      bank_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      vec_q   <= vec_d;
      if (load) bank_q <= lanes_in;
    end
  end

  // in_ready depends combinationally on out_ready in the last slot so a new
  // vector can be loaded in the same cycle the final lane leaves (no bubble).
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    vec_d     = vec_q;
    load      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      EMPTY: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_d = DRAIN;
          slot_d  = '0;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (slot_q == SLOT_LAST) begin
            in_ready = 1'b1;
            vec_d    = (vec_q == VEC_LAST) ? '0 : vec_q + 1'b1;
            slot_d   = '0;
            if (in_valid) load = 1'b1;
            else          state_d = EMPTY;
          end else begin
            slot_d = slot_q + 1'b1;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

`ifdef PIPE_SER_BITREV_EN
  assign out_lane = bitrev4(slot_q);
`else
  assign out_lane = slot_q;
`endif

  // Last-sample flags key on the slot, not the lane, so they hold in either order.
  assign out_last       = (state_q == DRAIN) && (slot_q == SLOT_LAST);
  assign out_frame_last = out_last && (vec_q == VEC_LAST);

  pipe_ser_lane_mux #(.D_WIDTH(D_WIDTH)) u_mux (
    .bank_i (bank_q),
    .sel_i  (out_lane),
    .data_o (out_data)
  );

endmodule

// File: tb/tb_pipe_serializer.sv
// Randomized scoreboard bench for pipe_serializer; follows PIPE_SER_BITREV_EN if defined.
module tb_pipe_serializer;
  import pipe_ser_pkg::*;

  localparam int DW  = 192;
  localparam int VPF = 1024;

  typedef struct {
    logic [DW-1:0] d;
    logic [3:0]    lane;
    logic          last;
    logic          fl;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready, out_valid, out_last, out_frame_last;
  logic [DW-1:0] out_data;
  logic [3:0]    out_lane;
  logic [DW-1:0] r [16];

  exp_t q[$];
  int checks = 0, errors = 0;
  int acc_cnt = 0, acc_lim = 0, mvec = 0, fl_seen = 0, tmo = 0;
  int iv_mode = 0, or_mode = 0;
  bit pat_mode = 0, acc_now = 0, end_req = 0, done = 0;
  bit hold_v = 0;
  logic [DW-1:0] hold_d;
  logic [3:0]    hold_l;

  always #5 clk = ~clk;

  pipe_serializer #(.D_WIDTH(DW), .VEC_PER_FRAME(VPF)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .R0_in(r[0]),   .R1_in(r[1]),   .R2_in(r[2]),   .R3_in(r[3]),
    .R4_in(r[4]),   .R5_in(r[5]),   .R6_in(r[6]),   .R7_in(r[7]),
    .R8_in(r[8]),   .R9_in(r[9]),   .R10_in(r[10]), .R11_in(r[11]),
    .R12_in(r[12]), .R13_in(r[13]), .R14_in(r[14]), .R15_in(r[15]),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_lane(out_lane), .out_last(out_last), .out_frame_last(out_frame_last)
  );

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Emission order of lanes: natural, or bit-reversed slot index.
  function automatic logic [3:0] lane_of(input int s);
    logic [3:0] sv, l;
    sv = 4'(s);
    l  = sv;
`ifdef PIPE_SER_BITREV_EN
    for (int b = 0; b < 4; b++) l[b] = sv[3-b];
`endif
    return l;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Stimulus driver: holds an offered vector until it is accepted.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      in_valid = 1'b0;
    end else if (!in_valid || acc_now) begin
      if (acc_cnt >= acc_lim)  in_valid = 1'b0;
      else if (iv_mode == 1)   in_valid = 1'b1;
      else if (iv_mode == 2)   in_valid = ($urandom_range(0, 2) != 0);
      else                     in_valid = 1'b0;
      for (int k = 0; k < 16; k++) r[k] = pat_mode ? DW'(k + 1) : rnd();
    end
    case (or_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor/scoreboard: samples mid-cycle, before the edge that completes handshakes.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_data", out_data, '0);
      chk("rst_out_lane", out_lane, 4'd0);
      chk("rst_out_last", out_last, 1'b0);
      chk("rst_frame_last", out_frame_last, 1'b0);
      q.delete();
      hold_v  = 0;
      mvec    = 0;
      fl_seen = 0;
      acc_now = 0;
    end else begin
      chk("out_valid", out_valid, q.size() != 0);
      chk("in_ready", in_ready, (q.size() == 0) || (q[0].last && out_ready));
      if (out_valid && q.size() != 0) begin
        if (hold_v) begin
          chk("hold_data", out_data, hold_d);
          chk("hold_lane", out_lane, hold_l);
        end
        chk("out_data", out_data, q[0].d);
        chk("out_lane", out_lane, q[0].lane);
        chk("out_last", out_last, q[0].last);
        chk("out_frame_last", out_frame_last, q[0].fl);
        if (out_ready) begin
          if (out_frame_last) fl_seen++;
          void'(q.pop_front());
          hold_v = 0;
        end else begin
          hold_v = 1;
          hold_d = out_data;
          hold_l = out_lane;
        end
      end
      acc_now = in_valid && in_ready;
      if (acc_now) begin
        for (int s = 0; s < 16; s++) begin
          exp_t e;
          e.lane = lane_of(s);
          e.d    = r[e.lane];
          e.last = (s == 15);
          e.fl   = (s == 15) && (mvec == VPF - 1);
          q.push_back(e);
        end
        mvec = (mvec + 1) % VPF;
        acc_cnt++;
      end
      if (end_req && !done) begin
        chk("timeouts", tmo, 0);
        chk("queue_empty", q.size(), 0);
        chk("frame_last_count", fl_seen, 1);
        chk("accept_count", acc_cnt, acc_lim);
        done = 1;
      end
    end
  end

  task automatic wait_drain(input int n);
    for (int i = 0; i < n; i++) begin
      if (acc_cnt >= acc_lim && q.size() == 0 && !in_valid) return;
      @(posedge clk);
    end
    tmo++;
  endtask

  task automatic do_reset();
    acc_lim = acc_cnt;
    @(posedge clk); #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 16; k++) r[k] = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Directed single vector, Rk = k+1
    pat_mode = 1; iv_mode = 1; or_mode = 0;
    acc_lim = acc_cnt + 1;
    wait_drain(100);

    // Back-to-back vectors
    pat_mode = 0;
    acc_lim = acc_cnt + 2;
    wait_drain(100);

    // out_ready toggling every cycle
    or_mode = 1;
    acc_lim = acc_cnt + 2;
    wait_drain(200);

    // Random valid/ready
    iv_mode = 2; or_mode = 2;
    acc_lim = acc_cnt + 20;
    wait_drain(2000);

    // Reset in the middle of a vector at slot 7
    iv_mode = 1; or_mode = 0;
    acc_lim = acc_cnt + 1;
    for (int i = 0; i < 100 && acc_cnt < acc_lim; i++) @(posedge clk);
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    acc_lim = acc_cnt + 1;
    wait_drain(100);

    // Full frame plus one vector to see the counter wrap
    do_reset();
    acc_lim = acc_cnt + VPF + 1;
    wait_drain(20000);

    end_req = 1;
    for (int i = 0; i < 10 && !done; i++) @(posedge clk);
    if (!done) begin
      $display("FAIL end_checks: got not_run expected run");
      $fatal(1, "end checks never executed");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
